ps2_key_event_queue: RTL

PS2_KEY_EVENT_QUEUE -- requirements
Module: ps2_key_event_queue

---
 rtl/ps2_key_event_queue.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_queue.sv
// PS/2 scancode decoder feeding a small event FIFO: turns raw set-2 bytes into
// make events tagged with extension and modifier state, with optional repeat suppression.
module ps2_key_event_queue #(
   parameter int SUPPRESS_REPEAT = 1,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic [7:0] byte_in,
   input  logic       byte_valid_in,
   output logic       evt_valid_out,
   input  logic       evt_ready_in,
   output logic [7:0] evt_code_out,
   output logic       evt_ext_out,
   output logic       evt_shift_out,
   output logic       evt_ctrl_out,
   output logic       evt_enter_out,
   output logic       evt_bksp_out,
   output logic       overflow_out
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_SKIP} state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       shift;
      logic       ctrl;
   } evt_t;

   state_t           state_q, state_d;
   logic [2:0]       skip_q, skip_d;
   logic             shift_l_q, shift_l_d, shift_r_q, shift_r_d;
   logic             ctrl_l_q, ctrl_l_d, ctrl_r_q, ctrl_r_d;
   logic             held_q, held_d, held_ext_q, held_ext_d;
   logic [7:0]       held_code_q, held_code_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             overflow_q, overflow_d;
   evt_t             mem_q [FIFO_DEPTH];

   logic is_prefix, is_ignored, is_fake_shift;
   logic make_vld, brk_vld, key_ext;
   logic is_shift_key, is_ctrl_key, is_mod, repeat_hit;
   logic push, pop, full, push_ok, head_vld;
   evt_t new_evt, head;

   assign is_prefix     = (byte_in == 8'hE0) || (byte_in == 8'hF0) || (byte_in == 8'hE1);
   assign is_ignored    = (byte_in == 8'hAA) || (byte_in == 8'hFA) || (byte_in == 8'hFE) ||
                          (byte_in == 8'hEE) || (byte_in == 8'h00) || (byte_in == 8'hFF);
   assign is_fake_shift = (byte_in == 8'h12) || (byte_in == 8'h59);

   // Decoder state register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         skip_q  <= 3'd0;
      end else begin
         // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
         state_q <= state_d;
         skip_q  <= skip_d;
      end
   end

   // Decoder next-state logic.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      state_d = state_q;
      skip_d  = skip_q;
      if (byte_valid_in) begin
         case (state_q)
            S_IDLE: begin
               if (byte_in == 8'hE0)      state_d = S_E0;
               else if (byte_in == 8'hF0) state_d = S_F0;
               else if (byte_in == 8'hE1) begin
                  state_d = S_SKIP;
                  skip_d  = 3'd7;
               end
            end
            S_E0:          state_d = (byte_in == 8'hF0) ? S_E0F0 : S_IDLE;
            S_F0, S_E0F0:  state_d = S_IDLE;
            S_SKIP: begin
               skip_d = skip_q - 3'd1;
               if (skip_q <= 3'd1) state_d = S_IDLE;
            end
            default:       state_d = S_IDLE;
         endcase
      end
   end

   // Decoder outputs: one-cycle make/break strobes for the current byte.
   always_comb begin
      make_vld = 1'b0;
      brk_vld  = 1'b0;
      key_ext  = 1'b0;
      if (byte_valid_in) begin
         case (state_q)
            S_IDLE: make_vld = !is_prefix && !is_ignored;
            S_E0: begin
               make_vld = (byte_in != 8'hF0) && !is_fake_shift;
               key_ext  = 1'b1;
            end
            S_F0:   brk_vld = 1'b1;
            S_E0F0: begin
               brk_vld = 1'b1;
               key_ext = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // E0-prefixed 12/59 are fake shifts, so only the plain codes count as shift keys.
   assign is_shift_key = !key_ext && is_fake_shift;
   assign is_ctrl_key  = (byte_in == 8'h14);
   assign is_mod       = is_shift_key || is_ctrl_key;
   assign repeat_hit   = held_q && (held_ext_q == key_ext) && (held_code_q == byte_in);
   assign push         = make_vld && !is_mod && !((SUPPRESS_REPEAT != 0) && repeat_hit);

   always_comb begin
      shift_l_d   = shift_l_q;
      shift_r_d   = shift_r_q;
      ctrl_l_d    = ctrl_l_q;
      ctrl_r_d    = ctrl_r_q;
      held_d      = held_q;
      held_ext_d  = held_ext_q;
      held_code_d = held_code_q;
      if (make_vld || brk_vld) begin
         if (is_shift_key && byte_in == 8'h12) shift_l_d = make_vld;
         if (is_shift_key && byte_in == 8'h59) shift_r_d = make_vld;
         if (is_ctrl_key && !key_ext)          ctrl_l_d  = make_vld;
         if (is_ctrl_key && key_ext)           ctrl_r_d  = make_vld;
      end
      if (make_vld && !is_mod) begin
         held_d      = 1'b1;
         held_ext_d  = key_ext;
         held_code_d = byte_in;
      end else if (brk_vld && repeat_hit) begin
         held_d = 1'b0;
      end
   end

   assign head_vld = (cnt_q != '0);
   assign full     = (cnt_q == FULL_CNT);
   assign pop      = head_vld && evt_ready_in;
   assign push_ok  = push && (!full || pop);
   assign new_evt  = '{code: byte_in, ext: key_ext,
                       shift: shift_l_q | shift_r_q, ctrl: ctrl_l_q | ctrl_r_q};

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      overflow_d = overflow_q | (push && !push_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         shift_l_q   <= 1'b0;
         shift_r_q   <= 1'b0;
         ctrl_l_q    <= 1'b0;
         ctrl_r_q    <= 1'b0;
         held_q      <= 1'b0;
         held_ext_q  <= 1'b0;
         held_code_q <= 8'h00;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         overflow_q  <= 1'b0;
      end else begin
         shift_l_q   <= shift_l_d;
         shift_r_q   <= shift_r_d;
         ctrl_l_q    <= ctrl_l_d;
         ctrl_r_q    <= ctrl_r_d;
         held_q      <= held_d;
         held_ext_q  <= held_ext_d;
         held_code_q <= held_code_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         overflow_q  <= overflow_d;
      end
   end

   // NOTE: queue storage has no reset; entries are only visible while cnt_q says they are valid.
   always_ff @(posedge clk_in) begin
      if (push_ok) mem_q[wr_ptr_q] <= new_evt;
   end

   // Gating with head_vld keeps every evt_* output at zero while empty or in reset.
   assign head          = mem_q[rd_ptr_q];
   assign evt_valid_out = head_vld;
   assign evt_code_out  = head_vld ? head.code : 8'h00;
   assign evt_ext_out   = head_vld && head.ext;
   assign evt_shift_out = head_vld && head.shift;
   assign evt_ctrl_out  = head_vld && head.ctrl;
   assign evt_enter_out = head_vld && (head.code == 8'h5A);
   assign evt_bksp_out  = head_vld && (head.code == 8'h66);
   assign overflow_out  = overflow_q;

endmodule
